// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: double-buffered WS2812 pixel store with a fixed-rate frame scheduler
module ws2812_frame_ctrl #(
    parameter int LEDS        = 8,
    parameter int ADDR_W      = 3,
    parameter int FRAME_TICKS = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic              commit,
    output logic              commit_pending,
    output logic [23:0]       pix_rgb,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    input  logic              drv_busy,
    output logic [15:0]       frame_count
);
    localparam int TW = $clog2(FRAME_TICKS);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [TW-1:0] T_MAX = TW'(FRAME_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEDS - 1);
    localparam logic [1:0] S_WAIT = 2'd0, S_STREAM = 2'd1, S_DRAIN = 2'd2;

    logic [23:0] bank0 [DEPTH];
    logic [23:0] bank1 [DEPTH];
    logic              front;
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx, nidx;
    logic [TW-1:0]     timer;
    logic              frame_start, swap, new_front, wr_ok, hs;
    logic [23:0]       first_word, next_word;

    always_comb begin
        frame_start = (state == S_WAIT) && (timer == T_MAX) && !drv_busy;
        swap        = frame_start && commit_pending;
        new_front   = front ^ swap;
        wr_ok       = wr_en && (32'(wr_addr) < LEDS);
        hs          = pix_valid && pix_ready;
        nidx        = idx + 1'b1;
        // a write landing on a swapping edge targets the bank about to become front
        first_word  = (swap && wr_ok && wr_addr == '0) ? wr_rgb : (new_front ? bank1[0] : bank0[0]);
        next_word   = front ? bank1[nidx] : bank0[nidx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_ok) begin
            if (front) bank0[wr_addr] <= wr_rgb;
            else bank1[wr_addr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front          <= 1'b0;
            commit_pending <= 1'b0;
            pix_valid      <= 1'b0;
            pix_last       <= 1'b0;
            pix_rgb        <= '0;
            frame_count    <= '0;
            state          <= S_WAIT;
            timer          <= T_MAX;
            idx            <= '0;
        end else begin
            timer          <= frame_start ? '0 : (timer == T_MAX ? timer : timer + 1'b1);
            commit_pending <= commit || (commit_pending && !frame_start);
            if (frame_start) begin
                front       <= new_front;
                idx         <= '0;
                frame_count <= frame_count + 1'b1;
                state       <= S_STREAM;
                pix_valid   <= 1'b1;
                pix_last    <= (LEDS == 1);
                pix_rgb     <= first_word;
            end else if (state == S_STREAM && hs) begin
                if (pix_last) begin
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    state     <= S_DRAIN;
                end else begin
                    idx      <= nidx;
                    pix_rgb  <= next_word;
                    pix_last <= (nidx == LAST);
                end
            end else if (state == S_DRAIN && !drv_busy) begin
                state <= S_WAIT;
            end
        end
    end
endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
Frame scheduler and double-buffered pixel store for a WS2812 LED chain. A host writes per-LED 24-bit GRB/RGB words into a back buffer, then requests a commit. At each frame boundary the controller swaps buffers when a commit is pending. It then streams one word per LED, over a valid/ready handshake, to the downstream bit serializer at a fixed frame rate.

Parameters:
LEDS, 8, number of LEDs in the chain (>=1)
ADDR_W, 3, pixel address width; 2**ADDR_W >= LEDS
FRAME_TICKS, 200000, clk cycles between frame starts (60 Hz at 12 MHz); >=2

Ports:
clk  input  1  system clock (12 MHz nominal)
reset  input  1  asynchronous, active-high reset
wr_en  input  1  host write strobe, one word per cycle
wr_addr  input  ADDR_W  LED index for write
wr_rgb  input  24  colour word {red,green,blue}
commit  input  1  single-cycle pulse: back buffer is complete
commit_pending  output  1  commit accepted, swap not yet done
pix_rgb  output  24  colour word to serializer
pix_valid  output  1  pix_rgb valid
pix_ready  input  1  serializer accepts word this cycle
pix_last  output  1  current word is the last LED of the frame
drv_busy  input  1  serializer still shifting bits or in latch/reset gap
frame_count  output  16  frames started, wraps at 65535->0

Behaviour:
- Storage: two banks, LEDS x 24 bits each, and a front-select bit. The host writes the back bank. The stream reads the front bank.
- Reset (async): both banks cleared to 0; front=bank0; commit_pending=0; pix_valid=0; pix_last=0; pix_rgb=0; frame_count=0; state=WAIT; timer=FRAME_TICKS-1 (saturated), so the first frame starts on the first clock after reset release with drv_busy=0. Reset mid-frame aborts the stream immediately.
- Writes: when wr_en=1 and wr_addr<LEDS, the back bank word is written at that edge. When wr_addr>=LEDS, the write is ignored. Writes are accepted in every state.
- Commit: commit=1 sets commit_pending at the next edge. A repeated commit while pending has no additional effect.
- Timer: counts up each cycle and saturates at FRAME_TICKS-1. It is cleared to 0 on the frame-start edge. Width is clog2(FRAME_TICKS).
- States:
  WAIT: the frame start fires when timer==FRAME_TICKS-1 and drv_busy==0. On that edge:
    - if commit_pending (registered value), toggle front and clear commit_pending;
    - idx<=0; timer<=0; frame_count++; ->STREAM.
  STREAM:
    - pix_valid=1, pix_rgb=front[idx], pix_last=(idx==LEDS-1). All outputs are registered and valid on the first STREAM cycle.
    - On pix_valid&pix_ready: idx++, and the next word is presented the following cycle (back-to-back handshakes supported, 1 word/cycle max).
    - On the handshake with pix_last=1: pix_valid<=0, pix_last<=0, ->DRAIN.
    - pix_rgb holds stable while pix_valid=1 and pix_ready=0.
  DRAIN: wait for drv_busy==0, then ->WAIT. If the timer has already saturated, the next frame starts on the following cycle; otherwise it starts when the timer saturates.
- Simultaneous events:
  - commit on the frame-start edge: not used for this swap; commit_pending=1 afterwards, and the swap occurs at the next frame.
  - Write on the frame-start edge where a swap occurs: the write lands in the pre-swap back bank. That bank becomes front, so the write is included in the frame now starting.
- After a swap, the back bank holds the previous front contents; no copy is made. The host rewrites the words it needs.
- Frames repeat continuously. Without a commit, the same front contents are retransmitted each frame.
- Latency: frame start to first pix_valid = 1 cycle. Commit to visible output = up to one frame period plus the drain time.

Test Plan:
- LEDS=4, FRAME_TICKS=100, pix_ready=1, drv_busy=0, after reset -> pix_valid high on cycle 1 after reset release for 4 cycles, words all 0x000000, pix_last on the 4th, frame_count=1.
- Write addr0..3=0x110000,0x002200,0x000033,0xFFFFFF; commit -> commit_pending=1 until the next frame start. That frame streams the four words in order, then commit_pending=0. The frame after repeats the same words.
- pix_ready toggling 1,0,0,1... -> pix_rgb stable during stalls, no word skipped or duplicated, exactly 4 handshakes per frame.
- drv_busy held high 300 cycles after the last handshake -> no frame start until drv_busy falls; the next frame starts 1 cycle after the fall, since the timer is saturated.
- commit on the exact frame-start cycle -> no swap that frame, commit_pending=1, swap at the following frame. Write to addr 7 (>=LEDS) -> no bank change.
- Assert reset mid-STREAM (idx=2) -> pix_valid=0 and buffers zeroed immediately. After release, a new frame of zeros with frame_count=1.
